// File: rtl/hd44780_read_operation_pkg.sv
// Shared definitions for the HD44780 read strobe: FSM states, default bus timing
// at 12 MHz, and the busy-flag bit position on DB.
package hd44780_read_operation_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_E_HIGH,
        ST_E_LOW,
        ST_DONE
    } rd_state_e;

    localparam int T_AS_DEF     = 1;
    localparam int T_EH_DEF     = 3;
    localparam int T_EL_DEF     = 3;
    localparam int POLL_MAX_DEF = 255;
    localparam int BF_BIT       = 7;
    localparam int TMR_W        = 8;

endpackage

// File: rtl/hd44780_phase_timer.sv
// Loadable down-counter shared by the SETUP / E_HIGH / E_LOW phases.
// Reloaded on every phase entry; 'expired' marks the last cycle of the phase.
module hd44780_phase_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_expired
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= i_val;
        end else if (cnt_q > W'(1)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign o_expired = (cnt_q == W'(1));

endmodule

// File: rtl/hd44780_read_operation.sv
// One RW=1 bus cycle to an HD44780 (status or data read), with optional busy-flag
// polling. Outputs are registered one cycle behind the FSM state.
module hd44780_read_operation
    import hd44780_read_operation_pkg::*;
#(
    parameter int T_AS_CYC = T_AS_DEF,
    parameter int T_EH_CYC = T_EH_DEF,
    parameter int T_EL_CYC = T_EL_DEF,
    parameter bit FOUR_BIT = 1'b0,
    parameter int POLL_MAX = POLL_MAX_DEF
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic       i_poll,
    input  logic [7:0] i_db,
    output logic       o_rs,
    output logic       o_rw,
    output logic       o_e,
    output logic       o_bus_rel,
    output logic       o_busy,
    output logic [7:0] o_data,
    output logic       o_done,
    output logic       o_timeout
);

    localparam logic [7:0] POLL_LAST = 8'(POLL_MAX - 1);

    rd_state_e        state_q, state_d;
    logic             rs_q, poll_q, nib_q;
    logic [7:0]       data_q, poll_cnt_q;
    logic             rs_out_q, rw_q, e_q, rel_q, busy_q, done_q, to_q;
    logic [7:0]       dout_q;

    logic             tmr_ld, tmr_exp;
    logic [TMR_W-1:0] tmr_val;
    logic             start_ok, nib_more, poll_more;

    // busy_q lags the state by a cycle, so the DONE-cycle request is also refused
    assign start_ok  = i_start && (state_q == ST_IDLE) && !busy_q;
    assign nib_more  = FOUR_BIT && nib_q;
    assign poll_more = poll_q && data_q[BF_BIT] && (poll_cnt_q < POLL_LAST);

    hd44780_phase_timer #(.W(TMR_W)) u_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_load    (tmr_ld),
        .i_val     (tmr_val),
        .o_expired (tmr_exp)
    );

    always_comb begin
        state_d = state_q;
        tmr_ld  = 1'b0;
        tmr_val = TMR_W'(T_AS_CYC);
        case (state_q)
            ST_IDLE: if (start_ok) begin
                state_d = ST_SETUP;
                tmr_ld  = 1'b1;
            end
            ST_SETUP: if (tmr_exp) begin
                state_d = ST_E_HIGH;
                tmr_ld  = 1'b1;
                tmr_val = TMR_W'(T_EH_CYC);
            end
            ST_E_HIGH: if (tmr_exp) begin
                state_d = ST_E_LOW;
                tmr_ld  = 1'b1;
                tmr_val = TMR_W'(T_EL_CYC);
            end
            ST_E_LOW: if (tmr_exp) begin
                if (nib_more || poll_more) begin
                    state_d = ST_E_HIGH;
                    tmr_ld  = 1'b1;
                    tmr_val = TMR_W'(T_EH_CYC);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            rs_q       <= 1'b0;
            poll_q     <= 1'b0;
            nib_q      <= 1'b0;
            data_q     <= 8'h00;
            poll_cnt_q <= 8'h00;
            rs_out_q   <= 1'b0;
            rw_q       <= 1'b0;
            e_q        <= 1'b0;
            rel_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            to_q       <= 1'b0;
            dout_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_q != ST_IDLE);
            rw_q    <= (state_q != ST_IDLE);
            rel_q   <= (state_q != ST_IDLE);
            e_q     <= (state_q == ST_E_HIGH);
            done_q  <= (state_q == ST_DONE);
            to_q    <= (state_q == ST_DONE) && poll_q && data_q[BF_BIT];

            case (state_q)
                ST_IDLE: if (start_ok) begin
                    rs_q       <= i_rs && !i_poll;
                    poll_q     <= i_poll;
                    nib_q      <= 1'b0;
                    poll_cnt_q <= 8'h00;
                end
                ST_SETUP: rs_out_q <= rs_q;
                ST_E_HIGH: if (tmr_exp) begin
                    // 4-bit mode: both nibbles arrive on DB[7:4]
                    if (!FOUR_BIT)   data_q      <= i_db;
                    else if (!nib_q) data_q[7:4] <= i_db[7:4];
                    else             data_q[3:0] <= i_db[7:4];
                    if (FOUR_BIT) nib_q <= !nib_q;
                end
                ST_E_LOW: if (tmr_exp && !nib_more && poll_more) begin
                    poll_cnt_q <= poll_cnt_q + 8'h01;
                end
                ST_DONE: dout_q <= data_q;
                default: ;
            endcase
        end
    end

    assign o_rs      = rs_out_q;
    assign o_rw      = rw_q;
    assign o_e       = e_q;
    assign o_bus_rel = rel_q;
    assign o_busy    = busy_q;
    assign o_data    = dout_q;
    assign o_done    = done_q;
    assign o_timeout = to_q;

endmodule

// File: tb/tb_hd44780_read_operation.sv
// Bench: four DUT configurations, each fed by a table-driven LCD model that serves
// one DB value per E pulse; results checked against a per-read reference model.
module tb_hd44780_read_operation;

    localparam int ND = 4;
    localparam int FB[ND] = '{0, 1, 0, 0};
    localparam int PM[ND] = '{255, 3, 4, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic       start[ND], rs_i[ND], poll_i[ND];
    logic [7:0] db[ND];
    logic       o_rs[ND], o_rw[ND], o_e[ND], o_rel[ND], o_busy[ND], o_done[ND], o_to[ND];
    logic [7:0] o_data[ND];

    logic [7:0] tab[ND][32];
    int         base[ND], pcnt[ND], rise[ND];
    logic       eprev[ND];
    logic [7:0] junk;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    hd44780_read_operation #(.FOUR_BIT(1'b0), .POLL_MAX(255)) u0 (
        .i_clk(clk), .i_reset(rst), .i_start(start[0]), .i_rs(rs_i[0]), .i_poll(poll_i[0]),
        .i_db(db[0]), .o_rs(o_rs[0]), .o_rw(o_rw[0]), .o_e(o_e[0]), .o_bus_rel(o_rel[0]),
        .o_busy(o_busy[0]), .o_data(o_data[0]), .o_done(o_done[0]), .o_timeout(o_to[0]));
    hd44780_read_operation #(.FOUR_BIT(1'b1), .POLL_MAX(3)) u1 (
        .i_clk(clk), .i_reset(rst), .i_start(start[1]), .i_rs(rs_i[1]), .i_poll(poll_i[1]),
        .i_db(db[1]), .o_rs(o_rs[1]), .o_rw(o_rw[1]), .o_e(o_e[1]), .o_bus_rel(o_rel[1]),
        .o_busy(o_busy[1]), .o_data(o_data[1]), .o_done(o_done[1]), .o_timeout(o_to[1]));
    hd44780_read_operation #(.FOUR_BIT(1'b0), .POLL_MAX(4)) u2 (
        .i_clk(clk), .i_reset(rst), .i_start(start[2]), .i_rs(rs_i[2]), .i_poll(poll_i[2]),
        .i_db(db[2]), .o_rs(o_rs[2]), .o_rw(o_rw[2]), .o_e(o_e[2]), .o_bus_rel(o_rel[2]),
        .o_busy(o_busy[2]), .o_data(o_data[2]), .o_done(o_done[2]), .o_timeout(o_to[2]));
    hd44780_read_operation #(.FOUR_BIT(1'b0), .POLL_MAX(1)) u3 (
        .i_clk(clk), .i_reset(rst), .i_start(start[3]), .i_rs(rs_i[3]), .i_poll(poll_i[3]),
        .i_db(db[3]), .o_rs(o_rs[3]), .o_rw(o_rw[3]), .o_e(o_e[3]), .o_bus_rel(o_rel[3]),
        .o_busy(o_busy[3]), .o_data(o_data[3]), .o_done(o_done[3]), .o_timeout(o_to[3]));

    // LCD model: table entry for the current pulse while E is high, noise otherwise
    always_comb begin
        for (int g = 0; g < ND; g++)
            db[g] = o_e[g] ? tab[g][5'(pcnt[g] - base[g])] : junk;
    end

    always @(negedge clk) begin
        junk <= 8'($urandom);
        for (int g = 0; g < ND; g++) begin
            if (o_e[g] === 1'b1 && eprev[g] !== 1'b1) rise[g]++;
            if (o_e[g] !== 1'b1 && eprev[g] === 1'b1) pcnt[g]++;
            if (o_e[g] === 1'b1) begin
                checks++;
                assert (o_rw[g] === 1'b1 && o_rel[g] === 1'b1 && o_busy[g] === 1'b1)
                else begin
                    errors++;
                    $error("FAIL e_high_ctl dut%0d: observed rw=%b rel=%b busy=%b, expected all 1",
                           g, o_rw[g], o_rel[g], o_busy[g]);
                end
            end
            eprev[g] = o_e[g];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // bval/rval < 0 select random busy / ready bytes
    task automatic run_txn(input int d, input bit rs, input bit poll, input int nbusy,
                           input int bval, input int rval, input bit inject);
        logic [7:0] bytes[16];
        logic [7:0] eb;
        int reads, pulses, lat, j, r0, first_e, ecyc;
        bit eto, ers, busy_ok;
        for (int r = 0; r < 16; r++) begin
            if (r < nbusy) bytes[r] = (bval >= 0) ? 8'(bval) : {1'b1, 7'($urandom)};
            else bytes[r] = (rval >= 0) ? 8'(rval) : (poll ? {1'b0, 7'($urandom)} : 8'($urandom));
            if (FB[d] != 0) begin
                tab[d][2*r]   = {bytes[r][7:4], 4'($urandom)};
                tab[d][2*r+1] = {bytes[r][3:0], 4'($urandom)};
            end else begin
                tab[d][r]    = bytes[r];
                tab[d][r+16] = 8'($urandom);
            end
        end
        // reference: read until BF clear (poll) or POLL_MAX reads done
        reads = 0; eto = 1'b0; eb = 8'h00;
        while (reads < 16) begin
            eb = bytes[reads];
            reads++;
            if (!poll || !eb[7]) break;
            if (reads >= PM[d]) begin eto = 1'b1; break; end
        end
        pulses = reads * ((FB[d] != 0) ? 2 : 1);
        lat    = 2 + 6 * pulses;
        ers    = poll ? 1'b0 : rs;

        @(negedge clk);
        base[d] = pcnt[d]; r0 = rise[d];
        start[d] = 1'b1; rs_i[d] = rs; poll_i[d] = poll;
        @(negedge clk);
        start[d] = 1'b0; rs_i[d] = 1'($urandom); poll_i[d] = 1'($urandom);
        j = 0; busy_ok = 1'b1; first_e = -1; ecyc = 0;
        while (o_done[d] !== 1'b1 && j < lat + 10) begin
            if (j >= 1 && o_busy[d] !== 1'b1) busy_ok = 1'b0;
            if (o_e[d] === 1'b1) begin
                ecyc++;
                if (first_e < 0) first_e = j;
            end
            start[d] = inject ? 1'($urandom) : 1'b0;
            @(negedge clk);
            j++;
        end
        chk($sformatf("latency d%0d", d), j, lat);
        chk($sformatf("busy_held d%0d", d), busy_ok, 1);
        chk($sformatf("first_e d%0d", d), first_e, 2);
        chk($sformatf("e_cycles d%0d", d), ecyc, 3 * pulses);
        chk($sformatf("pulses d%0d", d), rise[d] - r0, pulses);
        chk($sformatf("data d%0d", d), o_data[d], eb);
        chk($sformatf("timeout d%0d", d), o_to[d], eto);
        chk($sformatf("rs d%0d", d), o_rs[d], ers);
        chk($sformatf("busy_at_done d%0d", d), o_busy[d], 1);
        // request in the DONE cycle must be dropped
        start[d] = 1'b1; rs_i[d] = 1'($urandom);
        @(negedge clk);
        start[d] = 1'b0;
        chk($sformatf("post_done d%0d", d), {o_done[d], o_busy[d], o_rw[d], o_rel[d], o_to[d]}, 0);
        chk($sformatf("data_hold d%0d", d), o_data[d], eb);
        chk($sformatf("rs_hold d%0d", d), o_rs[d], ers);
        @(negedge clk);
        chk($sformatf("done_cycle_start_ignored d%0d", d), o_busy[d], 0);
    endtask

    initial begin
        int j;
        bit seen;
        rst = 1'b1; junk = 8'h00;
        for (int g = 0; g < ND; g++) begin
            start[g] = 1'b0; rs_i[g] = 1'b0; poll_i[g] = 1'b0;
            base[g] = 0; pcnt[g] = 0; rise[g] = 0; eprev[g] = 1'b0;
            for (int r = 0; r < 32; r++) tab[g][r] = 8'h00;
        end
        repeat (2) @(negedge clk);
        for (int g = 0; g < ND; g++) begin
            chk($sformatf("reset_ctl d%0d", g),
                {o_rs[g], o_rw[g], o_e[g], o_rel[g], o_busy[g], o_done[g], o_to[g]}, 0);
            chk($sformatf("reset_data d%0d", g), o_data[g], 8'h00);
        end
        rst = 1'b0;

        run_txn(0, 1'b1, 1'b0, 0, -1, 8'hA5, 1'b0);   // plain data read
        run_txn(1, 1'b1, 1'b0, 0, -1, 8'h3C, 1'b0);   // 4-bit, two pulses
        run_txn(0, 1'b1, 1'b1, 3, 8'h80, 8'h12, 1'b0); // poll clears after 3 busy reads
        run_txn(2, 1'b0, 1'b1, 15, 8'hFF, -1, 1'b0);   // poll limit 4, BF stuck
        run_txn(3, 1'b0, 1'b1, 1, 8'hFF, -1, 1'b0);    // POLL_MAX=1, BF set -> timeout
        run_txn(3, 1'b1, 1'b1, 0, -1, -1, 1'b0);       // POLL_MAX=1, ready at once
        run_txn(1, 1'b0, 1'b1, 2, -1, -1, 1'b0);       // 4-bit poll, last allowed read
        run_txn(1, 1'b0, 1'b1, 3, -1, -1, 1'b0);       // 4-bit poll timeout
        run_txn(0, 1'b0, 1'b0, 1, -1, 8'h9F, 1'b1);    // status read, no poll: BF ignored

        for (int n = 0; n < 20; n++)
            run_txn($urandom_range(ND - 1), 1'($urandom), 1'($urandom),
                    $urandom_range(5), -1, -1, 1'($urandom));

        // reset in the middle of an E pulse
        @(negedge clk);
        start[0] = 1'b1; rs_i[0] = 1'b1; poll_i[0] = 1'b0;
        @(negedge clk);
        start[0] = 1'b0;
        j = 0;
        while (o_e[0] !== 1'b1 && j < 10) begin @(negedge clk); j++; end
        chk("rst_e_seen", o_e[0], 1);
        #2 rst = 1'b1;
        #1 chk("rst_async_drop", {o_e[0], o_busy[0], o_rw[0], o_rel[0]}, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (o_done[0] === 1'b1 || o_busy[0] === 1'b1) seen = 1'b1;
        end
        chk("rst_no_done", seen, 0);
        run_txn(0, 1'b1, 1'b0, 0, -1, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
